sprite_motion_ctrl: RTL

Per-frame motion and colour sequencer for the bouncing-sprite display. It runs in the LCD pixel clock domain and samples the LCD timing generator's frame-end strobe. Once per frame it advances the sprite position by a programmable step, reflects the sprite at the screen edges and rotates the one-hot sprite colour on every bounce. Outputs drive the bitmap viewport/offset logic and the RGB status LEDs. A debounced button cycles the speed; a pause input freezes motion.

---
 rtl/sprite_motion_if.sv | 23 ++
 rtl/sprite_motion_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/sprite_motion_if.sv
// Bundles the frame strobe, control inputs and sprite outputs of sprite_motion_ctrl.
// The master side drives the frame, pause and button inputs; the slave is the controller.
interface sprite_motion_if;
    logic       FRAME_END;
    logic       PAUSE;
    logic       BTN_SPEED;
    logic [9:0] X_POS;
    logic [9:0] Y_POS;
    logic [2:0] COLOR;
    logic [2:0] STEP;
    logic       BOUNCE;
    logic       CORNER;

    modport master (
        output FRAME_END, PAUSE, BTN_SPEED,
        input  X_POS, Y_POS, COLOR, STEP, BOUNCE, CORNER
    );

    modport slave (
        input  FRAME_END, PAUSE, BTN_SPEED,
        output X_POS, Y_POS, COLOR, STEP, BOUNCE, CORNER
    );
endinterface

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite motion sequencer: moves on each FRAME_END falling edge, reflects at
// the screen edges, rotates the one-hot colour per bounce and cycles speed from a button.
module sprite_motion_ctrl #(
    parameter int          SCREEN_WIDTH    = 800,
    parameter int          SCREEN_HEIGHT   = 480,
    parameter int          SPRITE_WIDTH    = 256,
    parameter int          SPRITE_HEIGHT   = 128,
    parameter int          START_X         = 270,
    parameter int          START_Y         = 160,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic            CLK,
    input  logic            RST,
    sprite_motion_if.slave  bus,
    output logic [1:0]      fsm_state
);
    localparam logic signed [10:0] X_MAX = 11'(SCREEN_WIDTH - SPRITE_WIDTH);
    localparam logic signed [10:0] Y_MAX = 11'(SCREEN_HEIGHT - SPRITE_HEIGHT);

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_CALC   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t state, state_next;

    logic        fe_prev;
    logic        frame_fall;
    logic [9:0]  x_q, y_q;
    logic        vx_neg, vy_neg;
    logic [2:0]  color_q, step_q;
    logic        bounce_q, corner_q;
    logic [9:0]  x_cand_q, y_cand_q;
    logic        vx_neg_cand_q, vy_neg_cand_q, x_refl_q, y_refl_q;
    logic        btn_sync1, btn_sync2;
    logic [15:0] deb_cnt;
    logic        press;

    logic signed [10:0] x_sum, y_sum;
    logic [9:0]         x_clamp, y_clamp;
    logic               x_hit, y_hit, x_dir, y_dir;

    assign frame_fall = fe_prev & ~bus.FRAME_END;
    assign press      = ~btn_sync2 && (deb_cnt == DEBOUNCE_CYCLES - 16'd1);

    always_comb begin
        x_sum   = vx_neg ? $signed({1'b0, x_q}) - $signed({8'b0, step_q})
                         : $signed({1'b0, x_q}) + $signed({8'b0, step_q});
        y_sum   = vy_neg ? $signed({1'b0, y_q}) - $signed({8'b0, step_q})
                         : $signed({1'b0, y_q}) + $signed({8'b0, step_q});
        x_clamp = x_sum[9:0];
        x_hit   = 1'b0;
        x_dir   = vx_neg;
        y_clamp = y_sum[9:0];
        y_hit   = 1'b0;
        y_dir   = vy_neg;
        // Landing exactly on an edge counts as a reflection, same as overshooting it.
        if (x_sum >= X_MAX) begin
            x_clamp = X_MAX[9:0];
            x_hit   = 1'b1;
            x_dir   = 1'b1;
        end else if (x_sum <= 11'sd0) begin
            x_clamp = 10'd0;
            x_hit   = 1'b1;
            x_dir   = 1'b0;
        end
        if (y_sum >= Y_MAX) begin
            y_clamp = Y_MAX[9:0];
            y_hit   = 1'b1;
            y_dir   = 1'b1;
        end else if (y_sum <= 11'sd0) begin
            y_clamp = 10'd0;
            y_hit   = 1'b1;
            y_dir   = 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_WAIT:   if (frame_fall && !bus.PAUSE) state_next = S_CALC;
            S_CALC:   state_next = S_COMMIT;
            S_COMMIT: state_next = S_WAIT;
            default:  state_next = S_WAIT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= S_WAIT;
            fe_prev       <= 1'b1;
            x_q           <= 10'(START_X);
            y_q           <= 10'(START_Y);
            vx_neg        <= 1'b0;
            vy_neg        <= 1'b0;
            color_q       <= 3'b001;
            step_q        <= 3'd1;
            bounce_q      <= 1'b0;
            corner_q      <= 1'b0;
            x_cand_q      <= '0;
            y_cand_q      <= '0;
            vx_neg_cand_q <= 1'b0;
            vy_neg_cand_q <= 1'b0;
            x_refl_q      <= 1'b0;
            y_refl_q      <= 1'b0;
            btn_sync1     <= 1'b1;
            btn_sync2     <= 1'b1;
            deb_cnt       <= '0;
        end else begin
            state     <= state_next;
            fe_prev   <= bus.FRAME_END;
            bounce_q  <= 1'b0;
            corner_q  <= 1'b0;
            btn_sync1 <= bus.BTN_SPEED;
            btn_sync2 <= btn_sync1;

            if (state == S_CALC) begin
                x_cand_q      <= x_clamp;
                y_cand_q      <= y_clamp;
                vx_neg_cand_q <= x_dir;
                vy_neg_cand_q <= y_dir;
                x_refl_q      <= x_hit;
                y_refl_q      <= y_hit;
            end

            if (state == S_COMMIT) begin
                x_q      <= x_cand_q;
                y_q      <= y_cand_q;
                vx_neg   <= vx_neg_cand_q;
                vy_neg   <= vy_neg_cand_q;
                bounce_q <= x_refl_q | y_refl_q;
                corner_q <= x_refl_q & y_refl_q;
                // A corner hit rotates the colour once, not once per axis.
                if (x_refl_q | y_refl_q) color_q <= {color_q[1:0], color_q[2]};
            end

            // Counter saturates at the threshold so a held button fires only once.
            if (btn_sync2)                        deb_cnt <= '0;
            else if (deb_cnt != DEBOUNCE_CYCLES)  deb_cnt <= deb_cnt + 16'd1;

            if (press) step_q <= (step_q == 3'd4) ? 3'd1 : step_q + 3'd1;
        end
    end

    assign bus.X_POS  = x_q;
    assign bus.Y_POS  = y_q;
    assign bus.COLOR  = color_q;
    assign bus.STEP   = step_q;
    assign bus.BOUNCE = bounce_q;
    assign bus.CORNER = corner_q;
    assign fsm_state  = state;
endmodule
